// File: rtl/ram_port_ctrl.sv
// Processor-side request port for an SDRAM block: issues single-word writes and reads,
// waits for read data with a timeout, and discards read data that nobody asked for.
module ram_port_ctrl #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] req_addr,
  input  logic [15:0] req_wr_data,
  input  logic        req_wr,
  input  logic        req_rd,
  output logic        req_ready,
  output logic [15:0] rsp_data,
  output logic        rsp_valid,
  output logic        err,
  input  logic        err_clr,
  output logic [7:0]  drop_cnt,
  output logic [23:0] ram_addr,
  output logic [15:0] ram_wr_data,
  output logic        ram_wr_en,
  output logic        ram_rd_en,
  input  logic        ram_busy,
  input  logic        ram_rd_ready,
  input  logic [15:0] ram_rd_data,
  output logic        ram_rd_ack
);

  localparam int CNT_W = $clog2(TIMEOUT + 2);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] ISSUE_WR = 2'd1;
  localparam logic [1:0] ISSUE_RD = 2'd2;
  localparam logic [1:0] WAIT_RD  = 2'd3;

  logic [1:0]       state_r;
  logic [1:0]       state_nxt_s;
  logic [CNT_W-1:0] wait_cnt_r;
  logic             rd_hit_s;
  logic             timeout_s;
  logic             drop_s;

  assign req_ready  = (state_r == IDLE);
  // Strobes are gated by rst so the SDRAM side sees nothing while reset is held.
  assign ram_wr_en  = rst && (state_r == ISSUE_WR) && !ram_busy;
  assign ram_rd_en  = rst && (state_r == ISSUE_RD) && !ram_busy;
  assign ram_rd_ack = rst && ram_rd_ready;

  assign rd_hit_s  = (state_r == WAIT_RD) && ram_rd_ready;
  assign timeout_s = (state_r == WAIT_RD) && !ram_rd_ready && (wait_cnt_r == CNT_W'(TIMEOUT));
  assign drop_s    = (state_r != WAIT_RD) && ram_rd_ready;

  // Next-state selection for the request FSM.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (req_wr) begin
          state_nxt_s = ISSUE_WR;
        end else if (req_rd) begin
          state_nxt_s = ISSUE_RD;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ISSUE_WR: begin
        if (!ram_busy) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = ISSUE_WR;
        end
      end
      ISSUE_RD: begin
        if (!ram_busy) begin
          state_nxt_s = WAIT_RD;
        end else begin
          state_nxt_s = ISSUE_RD;
        end
      end
      WAIT_RD: begin
        if (rd_hit_s || timeout_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = WAIT_RD;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State, request latches, wait counter and all registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r     <= IDLE;
      wait_cnt_r  <= '0;
      rsp_data    <= 16'h0000;
      rsp_valid   <= 1'b0;
      err         <= 1'b0;
      drop_cnt    <= 8'd0;
      ram_addr    <= 24'h000000;
      ram_wr_data <= 16'h0000;
    end else begin
      state_r <= state_nxt_s;

      if (state_r == IDLE && req_wr) begin
        ram_addr    <= req_addr;
        ram_wr_data <= req_wr_data;
      end else if (state_r == IDLE && req_rd) begin
        ram_addr    <= req_addr;
      end

      if (ram_rd_en) begin
        wait_cnt_r <= '0;
      end else if (state_r == WAIT_RD) begin
        wait_cnt_r <= wait_cnt_r + 1'b1;
      end

      rsp_valid <= rd_hit_s || timeout_s;
      if (rd_hit_s) begin
        rsp_data <= ram_rd_data;
      end else if (timeout_s) begin
        rsp_data <= 16'hFFFF;
      end

      // A timeout in the same cycle as err_clr leaves the flag set.
      if (timeout_s) begin
        err <= 1'b1;
      end else if (err_clr) begin
        err <= 1'b0;
      end

      if (drop_s && drop_cnt != 8'hFF) begin
        drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_ram_port_ctrl.sv
// Directed bench for ram_port_ctrl: write/read/busy/priority/timeout/drop/reset scenarios,
// with expected write beats and read responses held in scoreboard queues.
module tb_ram_port_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] req_addr;
  logic [15:0] req_wr_data;
  logic        req_wr, req_rd, req_ready;
  logic [15:0] rsp_data;
  logic        rsp_valid, err, err_clr;
  logic [7:0]  drop_cnt;
  logic [23:0] ram_addr;
  logic [15:0] ram_wr_data;
  logic        ram_wr_en, ram_rd_en, ram_busy, ram_rd_ready, ram_rd_ack;
  logic [15:0] ram_rd_data;

  int n_pass = 0;
  int n_total = 0;
  int wr_pulses = 0;
  int rd_pulses = 0;
  int ack_pulses = 0;
  int rsp_pulses = 0;

  logic [39:0] wr_q[$];
  logic [15:0] rsp_q[$];

  ram_port_ctrl #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .req_addr(req_addr), .req_wr_data(req_wr_data),
    .req_wr(req_wr), .req_rd(req_rd), .req_ready(req_ready),
    .rsp_data(rsp_data), .rsp_valid(rsp_valid), .err(err), .err_clr(err_clr),
    .drop_cnt(drop_cnt), .ram_addr(ram_addr), .ram_wr_data(ram_wr_data),
    .ram_wr_en(ram_wr_en), .ram_rd_en(ram_rd_en), .ram_busy(ram_busy),
    .ram_rd_ready(ram_rd_ready), .ram_rd_data(ram_rd_data), .ram_rd_ack(ram_rd_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic pedge();
    @(posedge clk);
    #1;
  endtask

  task automatic nedge();
    @(negedge clk);
  endtask

  // Scoreboard side: compare each DUT write beat and response against the queues.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (ram_wr_en) begin
        wr_pulses++;
        if (wr_q.size() == 0) chk("wr_unexpected", 40'd1, 40'd0);
        else chk("wr_beat", {ram_addr, ram_wr_data}, wr_q.pop_front());
      end
      if (ram_rd_en) rd_pulses++;
      if (ram_rd_ack) ack_pulses++;
      if (rsp_valid) begin
        rsp_pulses++;
        if (rsp_q.size() == 0) chk("rsp_unexpected", 40'd1, 40'd0);
        else chk("rsp_data", {24'd0, rsp_data}, {24'd0, rsp_q.pop_front()});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base_wr, base_rd, base_rsp, base_ack, seen;
    rst = 1'b0; req_addr = 24'h0; req_wr_data = 16'h0; req_wr = 1'b0; req_rd = 1'b0;
    err_clr = 1'b0; ram_busy = 1'b0; ram_rd_ready = 1'b0; ram_rd_data = 16'h0;
    pedge(); pedge();
    nedge();
    chk("rst_wr_en", {39'd0, ram_wr_en}, 40'd0);
    chk("rst_rd_ack", {39'd0, ram_rd_ack}, 40'd0);
    pedge();
    rst = 1'b1;
    nedge();
    chk("rst_ready", {39'd0, req_ready}, 40'd1);
    chk("rst_state", {rsp_data, drop_cnt, rsp_valid, err, 14'd0}, 40'd0);
    chk("rst_ram_addr", {ram_addr, ram_wr_data}, 40'd0);
    pedge();

    // Plain write, not busy.
    req_wr = 1'b1; req_addr = 24'h000123; req_wr_data = 16'hBEEF;
    wr_q.push_back({24'h000123, 16'hBEEF});
    pedge();
    req_wr = 1'b0;
    nedge();
    chk("wr_en_c1", {39'd0, ram_wr_en}, 40'd1);
    chk("wr_ready_c1", {39'd0, req_ready}, 40'd0);
    pedge();
    nedge();
    chk("wr_ready_c2", {39'd0, req_ready}, 40'd1);
    chk("wr_en_c2", {39'd0, ram_wr_en}, 40'd0);
    pedge();
    chk("wr_pulse_cnt", wr_pulses, 40'd1);

    // Busy stall for 5 cycles.
    ram_busy = 1'b1; req_wr = 1'b1; req_addr = 24'h00F00D; req_wr_data = 16'h5A5A;
    wr_q.push_back({24'h00F00D, 16'h5A5A});
    pedge();
    req_wr = 1'b0; req_addr = 24'hFFFFFF; req_wr_data = 16'h0000;
    for (int i = 0; i < 5; i++) begin
      nedge();
      chk("busy_no_wr", {38'd0, ram_wr_en, req_ready}, 40'd0);
      pedge();
    end
    ram_busy = 1'b0;
    nedge();
    chk("busy_release_wr", {39'd0, ram_wr_en}, 40'd1);
    pedge();
    nedge();
    chk("busy_ready", {39'd0, req_ready}, 40'd1);
    pedge();
    chk("busy_pulse_cnt", wr_pulses, 40'd2);

    // Read with data three cycles after ram_rd_en.
    base_rsp = rsp_pulses;
    req_rd = 1'b1; req_addr = 24'h00ABCD;
    pedge();
    req_rd = 1'b0; req_addr = 24'h0;
    nedge();
    chk("rd_en_c1", {39'd0, ram_rd_en}, 40'd1);
    chk("rd_addr", {16'd0, ram_addr}, {16'd0, 24'h00ABCD});
    pedge(); pedge(); pedge();
    ram_rd_ready = 1'b1; ram_rd_data = 16'h1234;
    rsp_q.push_back(16'h1234);
    nedge();
    chk("rd_ack", {38'd0, ram_rd_ack, rsp_valid}, 40'd2);
    pedge();
    ram_rd_ready = 1'b0; ram_rd_data = 16'h0;
    nedge();
    chk("rd_rsp", {rsp_data, 6'd0, rsp_valid, req_ready, 16'd0}, {16'h1234, 8'h03, 16'd0});
    pedge();
    chk("rd_rsp_cnt", rsp_pulses - base_rsp, 40'd1);

    // Simultaneous write and read: write wins.
    base_rd = rd_pulses;
    req_wr = 1'b1; req_rd = 1'b1; req_addr = 24'h000055; req_wr_data = 16'hA5A5;
    wr_q.push_back({24'h000055, 16'hA5A5});
    pedge();
    req_wr = 1'b0; req_rd = 1'b0;
    nedge();
    chk("prio_en", {38'd0, ram_wr_en, ram_rd_en}, 40'd2);
    pedge(); pedge(); pedge();
    chk("prio_no_rd", rd_pulses - base_rd, 40'd0);

    // Timeout: rd_en at cycle 1, counter 0..4 in WAIT_RD, response at cycle 7.
    req_rd = 1'b1; req_addr = 24'h000077;
    rsp_q.push_back(16'hFFFF);
    pedge();
    req_rd = 1'b0;
    seen = 0;
    for (int i = 1; i <= 20; i++) begin
      nedge();
      if (rsp_valid) begin seen = i; break; end
      pedge();
    end
    chk("to_latency", seen, 40'd7);
    chk("to_err_set", {39'd0, err}, 40'd1);
    pedge();
    err_clr = 1'b1;
    pedge();
    err_clr = 1'b0;
    nedge();
    chk("to_err_clr", {39'd0, err}, 40'd0);
    pedge();

    // Timeout coinciding with err_clr leaves err set.
    req_rd = 1'b1; err_clr = 1'b1;
    rsp_q.push_back(16'hFFFF);
    pedge();
    req_rd = 1'b0;
    seen = 0;
    for (int i = 1; i <= 20; i++) begin
      nedge();
      if (rsp_valid) begin seen = i; break; end
      pedge();
    end
    err_clr = 1'b0;
    chk("to2_latency", seen, 40'd7);
    pedge();
    nedge();
    chk("to2_err_kept", {39'd0, err}, 40'd1);
    pedge();

    // Unsolicited data in IDLE.
    base_ack = ack_pulses; base_rsp = rsp_pulses;
    chk("drop_start", {32'd0, drop_cnt}, 40'd0);
    for (int i = 0; i < 300; i++) begin
      ram_rd_ready = 1'b1; ram_rd_data = 16'($urandom);
      pedge();
      if (i == 99) begin
        nedge();
        chk("drop_mid", {32'd0, drop_cnt}, 40'd100);
      end
    end
    ram_rd_ready = 1'b0;
    pedge();
    chk("drop_acks", ack_pulses - base_ack, 40'd300);
    chk("drop_sat", {32'd0, drop_cnt}, 40'd255);
    chk("drop_no_rsp", rsp_pulses - base_rsp, 40'd0);

    // Reset while waiting for read data; late data is dropped afterwards.
    base_rsp = rsp_pulses;
    req_rd = 1'b1; req_addr = 24'h000999;
    pedge();
    req_rd = 1'b0;
    pedge();
    rst = 1'b0; ram_rd_ready = 1'b1; ram_rd_data = 16'h7777;
    nedge();
    chk("mid_rst_ack", {38'd0, ram_rd_ack, ram_rd_en}, 40'd0);
    pedge();
    rst = 1'b1; ram_rd_ready = 1'b0;
    nedge();
    chk("mid_rst_state", {req_ready, rsp_valid, err, drop_cnt, ram_addr, 5'd0}, {1'b1, 39'd0});
    ram_rd_ready = 1'b1;
    pedge();
    ram_rd_ready = 1'b0;
    nedge();
    chk("late_drop", {32'd0, drop_cnt}, 40'd1);
    pedge(); pedge();
    chk("mid_rst_no_rsp", rsp_pulses - base_rsp, 40'd0);
    chk("queues_empty", wr_q.size() + rsp_q.size(), 40'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
